// File: rtl/bin_down_timer_if.sv
// Control/status bundle for bin_down_timer.
// slave = timer side, master = controller side.
interface bin_down_timer_if #(
    parameter int N = 8
);
    logic         load;
    logic [N-1:0] din;
    logic         en;
    logic         auto_reload;
    logic [N-1:0] q;
    logic         min_tick;
    logic         busy;
    logic         done;

    modport master (
        output load, din, en, auto_reload,
        input  q, min_tick, busy, done
    );

    modport slave (
        input  load, din, en, auto_reload,
        output q, min_tick, busy, done
    );
endinterface

// File: rtl/bin_down_timer.sv
// Loadable N-bit down-counter/timer, one-shot or auto-reload.
// Optional clock-enable prescaler: define BIN_DOWN_TIMER_PRESCALE_EN.
module bin_down_timer #(
    parameter int N        = 8,
    parameter int PRESCALE = 4
) (
    input  logic            clk,
    input  logic            reset,
    bin_down_timer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_e;

    state_e       state_q, state_d;
    logic [N-1:0] q_q, q_d;
    logic [N-1:0] rld_q, rld_d;
    logic         step;
    logic         tc;

`ifdef BIN_DOWN_TIMER_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q, pre_d;

    assign step = bus.en & (pre_q == PMAX);

    always_comb begin
        pre_d = pre_q;
        if (bus.load) begin
            pre_d = '0;
        end else if (state_q == RUN && bus.en) begin
            pre_d = (pre_q == PMAX) ? '0 : pre_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pre_q <= '0;
        else       pre_q <= pre_d;
    end
`else
    assign step = bus.en;
`endif

    // Terminal event; a load in the same cycle always wins.
    assign tc = (state_q == RUN) & step & (q_q == '0) & ~bus.load;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.load) begin
            state_d = RUN;
        end else if (tc && !bus.auto_reload) begin
            state_d = EXPIRED;
        end
    end

    always_comb begin
        bus.q        = q_q;
        bus.min_tick = tc;
        bus.busy     = (state_q == RUN);
        bus.done     = (state_q == EXPIRED);
    end

    always_comb begin
        q_d   = q_q;
        rld_d = rld_q;
        if (bus.load) begin
            q_d   = bus.din;
            rld_d = bus.din;
        end else if (state_q == RUN && step) begin
            if (q_q != '0)           q_d = q_q - 1'b1;
            else if (bus.auto_reload) q_d = rld_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q   <= '0;
            rld_q <= '0;
        end else begin
            q_q   <= q_d;
            rld_q <= rld_d;
        end
    end
endmodule
